// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Contents: FSM state enum, reset level constant, index-width helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Level of w_rst that holds the block in reset
    localparam logic RST_ACTIVE = 1'b0;

    // Bits needed to index n items; never less than 1
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bus plus FIFO write port of the write-side arbiter.
// slave  : arbiter view (takes requests and fifo_full, drives grant/write signals)
// master : producer/FIFO view (opposite directions)
interface fifo_wr_arbiter_if
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned D_SIZE = 8,
    parameter int unsigned CNT_W  = 16
) ();
    localparam int unsigned ID_W = id_w(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*D_SIZE-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_inc;
    logic [D_SIZE-1:0]      fifo_data;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;
    logic [CNT_W-1:0]       beat_count;

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_inc, fifo_data, grant_id, busy, beat_count
    );

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_inc, fifo_data, grant_id, busy, beat_count
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Ports: req (request vector), ptr (search start), any (some request set),
//        idx (winning index, 0 when any=0).
module fifo_wr_arbiter_rr
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] idx
);
    logic [ID_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit is written last
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ID_W'((32'(ptr) + 32'(i)) % NREQ);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NREQ producers.
// Ports: wr_clk, w_rst (async, active-low) and the slave side of fifo_wr_arbiter_if:
//   req_valid/req_data/req_last in, req_ready out (one-hot or zero),
//   fifo_full in, fifo_wr_inc/fifo_data out, grant_id/busy/beat_count status out.
// A grant ends on the owner's last beat or after BURST_MAX beats; one idle
// arbitration cycle separates grants.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned D_SIZE    = 8,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             wr_clk,
    input  logic             w_rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned     ID_W      = id_w(NREQ);
    localparam int unsigned     BC_W      = id_w(BURST_MAX);
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BURST_MAX - 1);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [BC_W-1:0]   beat_cnt;
    logic              busy_q;
    logic [CNT_W-1:0]  beat_count_q;

    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic              beat_c;
    logic              release_c;
    logic [D_SIZE-1:0] data_sel_c;
    logic [ID_W-1:0]   next_ptr_c;

    fifo_wr_arbiter_rr #(.NREQ(NREQ)) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // A beat moves only for the owner, only in XFER, only with room in the FIFO
    assign beat_c     = (state == XFER) && bus.req_valid[grant_id] && !bus.fifo_full;
    assign release_c  = beat_c && (bus.req_last[grant_id] || (beat_cnt == BEAT_LAST));
    assign next_ptr_c = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Owner data mux
    always_comb begin
        data_sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                data_sel_c = bus.req_data[i*D_SIZE +: D_SIZE];
            end
        end
    end

    assign bus.fifo_wr_inc = beat_c;
    assign bus.req_ready   = beat_c ? (NREQ'(1) << grant_id) : '0;
    assign bus.fifo_data   = (state == XFER) ? data_sel_c : '0;
    assign bus.grant_id    = grant_id;
    assign bus.busy        = busy_q;
    assign bus.beat_count  = beat_count_q;

    // Grant FSM, burst counter and beat statistics
    always_ff @(posedge wr_clk or negedge w_rst) begin
        if (w_rst == RST_ACTIVE) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            beat_cnt     <= '0;
            busy_q       <= 1'b0;
            beat_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat_c) begin
                        beat_count_q <= beat_count_q + CNT_W'(1);
                        if (release_c) begin
                            rr_ptr <= next_ptr_c;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BC_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-requester beat queues feed the
// DUT, expected writes sit in a scoreboard queue and are popped on every write.
module tb_fifo_wr_arbiter;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned D_SIZE    = 8;
    localparam int unsigned BURST_MAX = 4;
    // Narrow counter keeps the wrap scenario short
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned ID_W      = $clog2(NREQ);

    typedef struct {
        logic [D_SIZE-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        int                id;
        logic [D_SIZE-1:0] data;
    } exp_t;

    logic wr_clk = 1'b0;
    logic w_rst;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .D_SIZE(D_SIZE), .CNT_W(CNT_W)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ), .D_SIZE(D_SIZE), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)
    ) dut (
        .wr_clk (wr_clk),
        .w_rst  (w_rst),
        .bus    (bus)
    );

    beat_t           pq[NREQ][$];
    exp_t            exp_q[$];
    int              wr_log[$];
    int              cyc = 0;
    logic [NREQ-1:0] acc = '0;
    logic            full_req = 1'b0;
    int              total = 0;
    int              bad = 0;

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc++;

    // Producer side: retire accepted beats, present the next head of each queue
    always @(posedge wr_clk) begin
        logic [NREQ-1:0]        v;
        logic [NREQ-1:0]        l;
        logic [NREQ*D_SIZE-1:0] d;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        acc = '0;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pq[i].size() > 0) begin
                v[i] = 1'b1;
                l[i] = pq[i][0].last;
                d[i*D_SIZE +: D_SIZE] = pq[i][0].data;
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.fifo_full = full_req;
    end

    // Write monitor and scoreboard
    always @(negedge wr_clk) begin
        exp_t e;
        acc = bus.req_ready;
        total++;
        if (bus.fifo_wr_inc === 1'b1 && bus.fifo_full === 1'b1) begin
            bad++;
            $display("FAIL wr_inc_while_full: wr_inc=%b full=%b at cyc %0d, required wr_inc=0",
                     bus.fifo_wr_inc, bus.fifo_full, cyc);
        end
        total++;
        if (bus.fifo_wr_inc === 1'b1) begin
            wr_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: id=%0d data=%h at cyc %0d, required no write",
                         bus.grant_id, bus.fifo_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant_id !== ID_W'(e.id) || bus.fifo_data !== e.data ||
                    bus.req_ready !== (NREQ'(1) << e.id)) begin
                    bad++;
                    $display("FAIL write_payload: got id=%0d data=%h ready=%b, required id=%0d data=%h ready=%b",
                             bus.grant_id, bus.fifo_data, bus.req_ready,
                             e.id, e.data, NREQ'(1) << e.id);
                end
            end
        end else if (bus.req_ready !== '0) begin
            bad++;
            $display("FAIL ready_without_write: ready=%b at cyc %0d, required 0", bus.req_ready, cyc);
        end
    end

    task automatic pq_push(input int id, input logic [D_SIZE-1:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        pq[id].push_back(b);
    endtask

    task automatic ex_push(input int id, input logic [D_SIZE-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push(input int id, input logic [D_SIZE-1:0] data, input logic last);
        pq_push(id, data, last);
        ex_push(id, data);
    endtask

    function automatic bit prod_empty();
        for (int i = 0; i < NREQ; i++) if (pq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) pq[i].delete();
        exp_q.delete();
        acc = '0;
        full_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        forever begin
            @(negedge wr_clk);
            #1;
            if (prod_empty() && exp_q.size() == 0 && bus.busy === 1'b0) break;
            k++;
            if (k >= budget) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: still busy=%b pending=%0d after %0d cycles, required idle",
                         name, bus.busy, exp_q.size(), budget);
                break;
            end
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        forever begin
            @(negedge wr_clk);
            #1;
            if (wr_log.size() >= n) break;
            k++;
            if (k >= budget) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: %0d writes seen, required %0d", name, wr_log.size(), n);
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge wr_clk);
        w_rst = 1'b0;
        #1;
        clear_all();
        repeat (2) @(negedge wr_clk);
        w_rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge wr_clk);
        #1;
        total++;
        if ({bus.busy, bus.grant_id, bus.beat_count, bus.fifo_wr_inc, bus.req_ready, bus.fifo_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b id=%0d cnt=%0d inc=%b ready=%b data=%h, required all 0",
                     bus.busy, bus.grant_id, bus.beat_count, bus.fifo_wr_inc, bus.req_ready, bus.fifo_data);
        end
        @(negedge wr_clk);
        w_rst = 1'b1;
        repeat (2) @(negedge wr_clk);
        #1;
        total++;
        if ({bus.busy, bus.grant_id, bus.beat_count, bus.fifo_wr_inc, bus.req_ready, bus.fifo_data} !== '0) begin
            bad++;
            $display("FAIL idle_outputs: busy=%b id=%0d cnt=%0d inc=%b ready=%b data=%h, required all 0",
                     bus.busy, bus.grant_id, bus.beat_count, bus.fifo_wr_inc, bus.req_ready, bus.fifo_data);
        end
    endtask

    task automatic test_single_burst();
        int c;
        @(negedge wr_clk);
        c = cyc;
        wr_log.delete();
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        wait_idle(20, "single_burst");
        total++;
        if (wr_log.size() != 3 || wr_log[0] != c + 2 || wr_log[1] != c + 3 || wr_log[2] != c + 4) begin
            bad++;
            $display("FAIL burst_timing: %0d writes first at %0d last at %0d, required 3 at %0d..%0d",
                     wr_log.size(), wr_log[0] - c, wr_log[wr_log.size()-1] - c, 2, 4);
        end
        // rr_ptr is now 3: requester 3 must beat requester 1
        @(negedge wr_clk);
        pq_push(1, 8'h44, 1'b1);
        pq_push(3, 8'h55, 1'b1);
        ex_push(3, 8'h55);
        ex_push(1, 8'h44);
        wait_idle(20, "ptr_after_burst");
    endtask

    task automatic test_round_robin();
        apply_reset();
        @(negedge wr_clk);
        wr_log.delete();
        pq_push(0, 8'h01, 1'b1);
        pq_push(0, 8'h05, 1'b1);
        pq_push(1, 8'h02, 1'b1);
        pq_push(2, 8'h03, 1'b1);
        pq_push(3, 8'h04, 1'b1);
        ex_push(0, 8'h01);
        ex_push(1, 8'h02);
        ex_push(2, 8'h03);
        ex_push(3, 8'h04);
        ex_push(0, 8'h05);
        wait_idle(40, "round_robin");
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_log.size() != 5 || wr_log[i+1] - wr_log[i] != 2) begin
                bad++;
                $display("FAIL rr_gap_%0d: writes=%0d gap=%0d, required 5 writes gap 2",
                         i, wr_log.size(), wr_log[i+1] - wr_log[i]);
            end
        end
    endtask

    task automatic test_burst_limit();
        apply_reset();
        @(negedge wr_clk);
        wr_log.delete();
        for (int k = 0; k < 10; k++) pq_push(1, 8'(8'h30 + k), k == 9);
        pq_push(2, 8'hA2, 1'b1);
        pq_push(3, 8'hA3, 1'b1);
        for (int k = 0; k < 4; k++) ex_push(1, 8'(8'h30 + k));
        ex_push(2, 8'hA2);
        ex_push(3, 8'hA3);
        for (int k = 4; k < 10; k++) ex_push(1, 8'(8'h30 + k));
        wait_idle(60, "burst_limit");
        total++;
        if (wr_log.size() != 12 || wr_log[3] - wr_log[0] != 3 || wr_log[4] - wr_log[3] != 2) begin
            bad++;
            $display("FAIL burst_cut: writes=%0d span=%0d gap=%0d, required 12 span 3 gap 2",
                     wr_log.size(), wr_log[3] - wr_log[0], wr_log[4] - wr_log[3]);
        end
        total++;
        if (bus.beat_count !== CNT_W'(12)) begin
            bad++;
            $display("FAIL burst_count: beat_count=%0d, required 12", bus.beat_count);
        end
    endtask

    task automatic test_full_stall();
        @(negedge wr_clk);
        wr_log.delete();
        for (int k = 0; k < 4; k++) push(0, 8'(8'h50 + k), k == 3);
        wait_writes(2, 20, "full_pre");
        full_req = 1'b1;
        repeat (5) begin
            @(negedge wr_clk);
            #1;
            total++;
            if ({bus.fifo_wr_inc, bus.req_ready, bus.busy, bus.grant_id, bus.beat_count} !==
                {1'b0, NREQ'(0), 1'b1, ID_W'(0), CNT_W'(14)}) begin
                bad++;
                $display("FAIL full_hold: inc=%b ready=%b busy=%b id=%0d cnt=%0d, required 0 0 1 0 14",
                         bus.fifo_wr_inc, bus.req_ready, bus.busy, bus.grant_id, bus.beat_count);
            end
        end
        full_req = 1'b0;
        wait_idle(20, "full_stall");
        total++;
        if (wr_log.size() != 4 || bus.beat_count !== CNT_W'(16)) begin
            bad++;
            $display("FAIL full_resume: writes=%0d cnt=%0d, required 4 and 16", wr_log.size(), bus.beat_count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge wr_clk);
        wr_log.delete();
        for (int k = 0; k < 4; k++) push(2, 8'(8'h60 + k), k == 3);
        wait_writes(2, 20, "reset_mid_pre");
        w_rst = 1'b0;
        #1;
        total++;
        if ({bus.fifo_wr_inc, bus.req_ready, bus.busy, bus.grant_id, bus.beat_count, bus.fifo_data} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: inc=%b ready=%b busy=%b id=%0d cnt=%0d data=%h, required all 0",
                     bus.fifo_wr_inc, bus.req_ready, bus.busy, bus.grant_id, bus.beat_count, bus.fifo_data);
        end
        clear_all();
        repeat (2) @(negedge wr_clk);
        w_rst = 1'b1;
        // rr_ptr back at 0: requester 0 must win over requester 3
        @(negedge wr_clk);
        pq_push(3, 8'h73, 1'b1);
        pq_push(0, 8'h70, 1'b1);
        ex_push(0, 8'h70);
        ex_push(3, 8'h73);
        wait_idle(20, "reset_restart");
        total++;
        if (bus.beat_count !== CNT_W'(2)) begin
            bad++;
            $display("FAIL reset_restart_count: beat_count=%0d, required 2", bus.beat_count);
        end
    endtask

    task automatic test_count_wrap();
        localparam int unsigned TOP = (1 << CNT_W) - 1;
        apply_reset();
        @(negedge wr_clk);
        for (int k = 0; k < TOP; k++) push(0, 8'(k), (k % 4 == 3) || (k == TOP - 1));
        wait_idle(2 * TOP, "wrap_fill");
        total++;
        if (bus.beat_count !== CNT_W'(TOP)) begin
            bad++;
            $display("FAIL wrap_top: beat_count=%0d, required %0d", bus.beat_count, TOP);
        end
        @(negedge wr_clk);
        push(0, 8'hEE, 1'b1);
        wait_idle(20, "wrap_step");
        total++;
        if (bus.beat_count !== CNT_W'(0)) begin
            bad++;
            $display("FAIL wrap_zero: beat_count=%0d, required 0", bus.beat_count);
        end
    endtask

    initial begin
        w_rst         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_burst_limit();
        test_full_stall();
        test_reset_mid();
        test_count_wrap();
        repeat (2) @(negedge wr_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
